ex_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage of the 5-stage RISC-V pipeline, adding the full RV32M operation set (generalised to XLEN) that the current single-cycle ALU lacks. It accepts one operation per start pulse and produces the result after a fixed, operation-dependent latency. While it works, it drives a stall request that the hazard logic ORs into its PC-write and IF/ID stall. A flush input aborts work belonging to squashed instructions.

---
 rtl/ex_muldiv_pkg.sv | 26 ++
 rtl/ex_muldiv_sign_fix.sv | 12 +
 rtl/ex_muldiv.sv | 163 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared types and decode constants for the EX-stage RV32M multiply/divide unit.
// funct3 op encoding, FSM state encoding, and the opcode/funct7 pair that selects M ops.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/ex_muldiv_sign_fix.sv
// Conditional two's-complement negation; purely combinational, no backpressure.
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic            neg,
  input  logic [XLEN-1:0] val,
  output logic [XLEN-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: XLEN+2 cycles per op (1 cycle for divide special cases).
// New work is accepted only in IDLE/DONE; stall_o holds the pipeline while an op is pending.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o
);

  localparam int CW = $clog2(XLEN) + 1;

  muldiv_state_e     state;
  muldiv_op_e        op_q;
  muldiv_op_e        op_in;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   opnd;
  logic [CW-1:0]     cnt;
  logic              neg_q;
  logic              neg_r;

  logic              s1_neg;
  logic              s2_neg;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     part;
  logic              fits;
  logic [XLEN-1:0]   diff;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign op_in  = muldiv_op_e'(op_i);
  assign s1_neg = src1_i[XLEN-1] &
                  (op_in == OP_MULH || op_in == OP_MULHSU || op_in == OP_DIV || op_in == OP_REM);
  assign s2_neg = src2_i[XLEN-1] &
                  (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);

  muldiv_sign_fix #(.XLEN(XLEN)) u_mag1 (.neg(s1_neg), .val(src1_i), .res(mag1));
  muldiv_sign_fix #(.XLEN(XLEN)) u_mag2 (.neg(s2_neg), .val(src2_i), .res(mag2));

  // Divide corner cases resolve at accept and skip the iteration entirely.
  assign div_zero = (src2_i == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                    (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&src2_i);
  assign special  = op_i[2] & (div_zero | div_ovf);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op_i[1] ? src1_i : '1;
    else          special_res = op_i[1] ? '0 : src1_i;
  end

  // Shift-add step: add multiplicand into the high half when the low bit is set.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});

  // Restoring step: partial remainder is XLEN+1 bits once the next dividend bit shifts in.
  assign part = {rem, acc[XLEN-1]};
  assign fits = (part >= {1'b0, opnd});
  assign diff = part[XLEN-1:0] - opnd;

  muldiv_sign_fix #(.XLEN(2*XLEN)) u_fix_prod (.neg(neg_q), .val(acc),            .res(prod_fix));
  muldiv_sign_fix #(.XLEN(XLEN))   u_fix_quo  (.neg(neg_q), .val(acc[XLEN-1:0]), .res(quo_fix));
  muldiv_sign_fix #(.XLEN(XLEN))   u_fix_rem  (.neg(neg_r), .val(rem),            .res(rem_fix));

  always_comb begin
    fix_res = rem_fix;
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = quo_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  assign stall_o = (start_i | busy_o) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      acc      <= '0;
      rem      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (flush_i) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_o <= 1'b0;
          state  <= ST_IDLE;
          if (start_i) begin
            op_q  <= op_in;
            neg_q <= s1_neg ^ s2_neg;
            neg_r <= s1_neg;
            cnt   <= CW'(XLEN);
            rem   <= '0;
            if (special) begin
              result_o <= special_res;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              busy_o <= 1'b1;
              state  <= ST_CALC;
              if (op_i[2]) begin
                acc  <= {{XLEN{1'b0}}, mag1};
                opnd <= mag2;
              end else begin
                acc  <= {{XLEN{1'b0}}, mag2};
                opnd <= mag1;
              end
            end
          end
        end
        ST_CALC: begin
          if (op_q[2]) begin
            rem            <= fits ? diff : part[XLEN-1:0];
            acc[XLEN-1:0]  <= {acc[XLEN-2:0], fits};
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          result_o <= fix_res;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed vectors with literal expectations plus a cycle-level
// behavioural model compared against the 32-bit DUT every cycle; a 16-bit instance gets a random pass.
module tb_ex_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] res;

  logic        h_start, h_flush;
  logic [2:0]  h_op;
  logic [15:0] h_a, h_b;
  logic        h_busy, h_done, h_stall;
  logic [15:0] h_res;

  ex_muldiv #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .src1_i(a), .src2_i(b),
    .flush_i(flush), .busy_o(busy), .done_o(done), .result_o(res), .stall_o(stall)
  );

  ex_muldiv #(.XLEN(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(h_start), .op_i(h_op), .src1_i(h_a), .src2_i(h_b),
    .flush_i(h_flush), .busy_o(h_busy), .done_o(h_done), .result_o(h_res), .stall_o(h_stall)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic at width w.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y, input int w);
    logic [63:0] mask, up;
    longint ux, uy, sx, sy, r;
    mask = (64'd1 << w) - 64'd1;
    ux = longint'(x & mask[31:0]);
    uy = longint'(y & mask[31:0]);
    sx = x[w-1] ? ux - (longint'(1) << w) : ux;
    sy = y[w-1] ? uy - (longint'(1) << w) : uy;
    case (f)
      3'd0: r = sx * sy;
      3'd1: r = (sx * sy) >>> w;
      3'd2: r = (sx * uy) >>> w;
      3'd3: begin up = ux[63:0] * uy[63:0]; r = longint'(up >> w); end
      3'd4: r = (uy == 0) ? -1 : sx / sy;
      3'd5: r = (uy == 0) ? -1 : ux / uy;
      3'd6: r = (uy == 0) ? sx : sx % sy;
      default: r = (uy == 0) ? ux : ux % uy;
    endcase
    return r[31:0] & mask[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x,
                                    input logic [31:0] y, input int w);
    logic [31:0] m, mn;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    mn = 32'd1 << (w - 1);
    return f[2] && (((y & m) == 0) || (!f[0] && ((x & m) == mn) && ((y & m) == m)));
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return m;
      2: return 32'd1 << (w - 1);
      3: return 32'd1;
      4: return $urandom & m;
      default: return $urandom_range(0, 9);
    endcase
  endfunction

  // Cycle-level model of the 32-bit unit: cycles left until done, pending result.
  int          m_left = 0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_res = '0, m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_res = '0;
    end else if (flush) begin
      m_left = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_done = 1'b1; m_res = m_pend; end
    end else begin
      m_done = 1'b0;
      if (start) begin
        if (is_special(op, a, b, 32)) begin
          m_done = 1'b1; m_res = ref_res(op, a, b, 32);
        end else begin
          m_left = 33; m_pend = ref_res(op, a, b, 32);
        end
      end
    end
    m_busy = (m_left > 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp busy",   {31'b0, busy},  {31'b0, m_busy});
      chk("cmp done",   {31'b0, done},  {31'b0, m_done});
      chk("cmp result", res, m_res);
      chk("cmp stall",  {31'b0, stall}, {31'b0, (start | m_busy) & ~flush});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat, input string name);
    int cyc;
    op = f; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({name, " latency"}, cyc, lat);
    chk(name, res, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int cyc, nd;
    logic [2:0]  f;
    logic [31:0] x, y, t;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    h_start = 1'b0; h_flush = 1'b0; h_op = '0; h_a = '0; h_b = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset busy",   {31'b0, busy}, 32'd0);
    chk("reset done",   {31'b0, done}, 32'd0);
    chk("reset result", res, 32'd0);
    tick();

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul 7*-3");
    chk("mul stall at done", {31'b0, stall}, 32'd0);
    tick();
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div -7/2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem -7/2");
    do_op(3'd5, 32'd7, 32'd2, 32'd3, 34, "divu 7/2");
    do_op(3'd7, 32'd7, 32'd2, 32'd1, 34, "remu 7/2");
    tick();
    do_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div 5/0");
    do_op(3'd7, 32'd5, 32'd0, 32'd5, 1, "remu 5/0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem ovf");
    tick();

    do_op(3'd4, 32'd100, 32'd7, 32'd14, 34, "b2b div");
    do_op(3'd0, 32'd12345, 32'd678, 32'h007F_B6F6, 34, "b2b mul");
    tick();

    // Flush in cycle 10 of a divide.
    op = 3'd4; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin tick(); cyc++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy",   {31'b0, busy}, 32'd0);
    chk("flush done",   {31'b0, done}, 32'd0);
    chk("flush result", res, 32'h007F_B6F6);
    nd = 0;
    repeat (40) begin tick(); if (done) nd++; end
    chk("flush no done", nd, 32'd0);

    // Start together with flush must be dropped; a special case would otherwise finish next cycle.
    op = 3'd4; a = 32'd5; b = 32'd0; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start+flush done",   {31'b0, done}, 32'd0);
    chk("start+flush busy",   {31'b0, busy}, 32'd0);
    chk("start+flush result", res, 32'h007F_B6F6);
    tick();

    // Reset in cycle 5 of a multiply.
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin tick(); cyc++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst busy",   {31'b0, busy},  32'd0);
    chk("rst done",   {31'b0, done},  32'd0);
    chk("rst result", res, 32'd0);
    chk("rst stall",  {31'b0, stall}, 32'd0);
    tick();

    repeat (40) begin
      f = 3'($urandom_range(0, 7));
      x = pick(32);
      y = pick(32);
      do_op(f, x, y, ref_res(f, x, y, 32), is_special(f, x, y, 32) ? 1 : 34, "rand32");
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (30) begin
      f = 3'($urandom_range(0, 7));
      t = pick(16); x = {16'b0, t[15:0]};
      t = pick(16); y = {16'b0, t[15:0]};
      h_op = f; h_a = x[15:0]; h_b = y[15:0]; h_start = 1'b1;
      tick();
      h_start = 1'b0;
      cyc = 1;
      while (!h_done && cyc < 40) begin tick(); cyc++; end
      chk("rand16 latency", cyc, is_special(f, x, y, 16) ? 32'd1 : 32'd18);
      chk("rand16 result", {16'b0, h_res}, ref_res(f, x, y, 16));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
